// File: rtl/regfile_exec_ctrl.sv
// Multi-cycle execution controller driving a 8x16 3R/1W register file.
// Latency: accept at E0, write strobe and done in cycle 3, ready again in cycle 4.
// Backpressure: in_ready low in READ/EXEC/WRITE; in_valid there is ignored, not queued.
module regfile_exec_ctrl (
  input  logic        clk,
  input  logic        RESET,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [2:0]  in_dst,
  input  logic [2:0]  in_src_a,
  input  logic [2:0]  in_src_b,
  input  logic [2:0]  in_src_c,
  input  logic [15:0] in_imm,
  output logic [2:0]  rf_read_addr_A,
  output logic [2:0]  rf_read_addr_B,
  output logic [2:0]  rf_read_addr_C,
  input  logic [15:0] rf_read_data_A,
  input  logic [15:0] rf_read_data_B,
  input  logic [15:0] rf_read_data_C,
  output logic        rf_write_enable,
  output logic [2:0]  rf_write_addr,
  output logic [15:0] rf_write_data,
  output logic        done,
  output logic [15:0] result,
  output logic        flag_z,
  output logic        flag_c
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_MAD = 3'b111;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [2:0]  dst_q, dst_d;
  logic [15:0] imm_q, imm_d;
  logic [2:0]  addr_a_q, addr_a_d;
  logic [2:0]  addr_b_q, addr_b_d;
  logic [2:0]  addr_c_q, addr_c_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic [15:0] opc_q, opc_d;
  logic [15:0] res_q, res_d;
  logic        fz_q, fz_d;
  logic        fc_q, fc_d;
  logic        wr_q, wr_d;

  logic [16:0] sum;
  logic [15:0] mad_val;
  logic [15:0] exec_val;
  logic        exec_c;

  // Reset forces IDLE asynchronously, so ready is also gated by RESET itself.
  assign in_ready        = (state_q == IDLE) & ~RESET;
  assign rf_read_addr_A  = addr_a_q;
  assign rf_read_addr_B  = addr_b_q;
  assign rf_read_addr_C  = addr_c_q;
  assign rf_write_enable = wr_q;
  assign done            = wr_q;
  assign rf_write_addr   = dst_q;
  assign rf_write_data   = res_q;
  assign result          = res_q;
  assign flag_z          = fz_q;
  assign flag_c          = fc_q;

  // ALU on captured operands; carry only meaningful for ADD (carry-out) and SUB (borrow).
  always_comb begin
    sum      = {1'b0, opa_q} + {1'b0, opb_q};
    mad_val  = opa_q * opb_q + opc_q;
    exec_val = 16'h0000;
    exec_c   = 1'b0;
    unique case (op_q)
      OP_ADD: begin exec_val = sum[15:0];       exec_c = sum[16];       end
      OP_SUB: begin exec_val = opa_q - opb_q;   exec_c = opa_q < opb_q; end
      OP_AND: exec_val = opa_q & opb_q;
      OP_OR:  exec_val = opa_q | opb_q;
      OP_XOR: exec_val = opa_q ^ opb_q;
      OP_SHL: exec_val = opa_q << opb_q[3:0];
      OP_LDI: exec_val = imm_q;
      OP_MAD: exec_val = mad_val;
    endcase
  end

  // Next-state and datapath capture for the IDLE/READ/EXEC/WRITE sequence.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dst_d    = dst_q;
    imm_d    = imm_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    addr_c_d = addr_c_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    opc_d    = opc_q;
    res_d    = res_q;
    fz_d     = fz_q;
    fc_d     = fc_q;
    wr_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d     = in_op;
          dst_d    = in_dst;
          imm_d    = in_imm;
          addr_a_d = in_src_a;
          addr_b_d = in_src_b;
          addr_c_d = in_src_c;
          state_d  = READ;
        end
      end
      READ: begin
        // Operands are sampled before the write-back, so dst==src is safe.
        opa_d   = rf_read_data_A;
        opb_d   = rf_read_data_B;
        opc_d   = rf_read_data_C;
        state_d = EXEC;
      end
      EXEC: begin
        res_d   = exec_val;
        fz_d    = (exec_val == 16'h0000);
        fc_d    = exec_c;
        wr_d    = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any in-flight instruction immediately.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      op_q     <= 3'd0;
      dst_q    <= 3'd0;
      imm_q    <= 16'h0000;
      addr_a_q <= 3'd0;
      addr_b_q <= 3'd0;
      addr_c_q <= 3'd0;
      opa_q    <= 16'h0000;
      opb_q    <= 16'h0000;
      opc_q    <= 16'h0000;
      res_q    <= 16'h0000;
      fz_q     <= 1'b0;
      fc_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      imm_q    <= imm_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      addr_c_q <= addr_c_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      opc_q    <= opc_d;
      res_q    <= res_d;
      fz_q     <= fz_d;
      fc_q     <= fc_d;
      wr_q     <= wr_d;
    end
  end

endmodule
